// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared types and constants for the multiplexed 7-segment display driver.
//   seg_t     : 7-bit active-low segment vector, ordered {g,f,e,d,c,b,a}
//   SEG_BLANK : all segments off
//   SEG_FONT  : full hex (0-F) active-low font
//   hex_decode: nibble -> active-low segment pattern
// -----------------------------------------------------------------------------
package display_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   localparam seg_t SEG_FONT [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

   function automatic seg_t hex_decode(input logic [3:0] nib);
      return SEG_FONT[nib];
   endfunction

endpackage

// File: rtl/display_scan_driver_tick_sync.sv
// -----------------------------------------------------------------------------
// tick_sync
//   Brings a slow divided clock into the system domain as data (2-FF
//   synchronizer) and emits a single-cycle tick on each rising edge.
//   Ports:
//     clk     : system clock
//     rst     : asynchronous active-high reset
//     i_async : divided clock, sampled as data
//     o_tick  : one-cycle pulse per rising edge of i_async
// -----------------------------------------------------------------------------
module tick_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_tick
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // Rising edge only; falling edges are ignored.
   assign o_tick = r_s2 & ~r_s3;

endmodule

// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
//   Drives a NUM_DIGITS-digit common-anode multiplexed 7-segment display from
//   the 50 MHz domain. The divided scan/blink clocks are sampled as data and
//   turned into ticks. New values are staged in a pending register and only
//   committed at the frame boundary (digit index wrapping to 0) so a frame is
//   never drawn with a mix of old and new digits.
//   Ports:
//     clk50Mhz   : system clock
//     rst        : asynchronous active-high reset
//     clk191hz   : scan clock (data), one digit advance per rising edge
//     clk6hz     : blink clock (data), blink phase toggles per rising edge
//     value      : hex nibbles, digit 0 = value[3:0]
//     load       : one-cycle capture request for value
//     dp         : per-digit decimal point enable (live)
//     blink_mask : per-digit blink enable
//     loaded     : one-cycle pulse when a new value is committed
//     an_n       : active-low one-hot anode select
//     seg_n      : active-low segments {g,f,e,d,c,b,a}
//     dp_n       : active-low decimal point
//     digit_idx  : currently driven digit
// -----------------------------------------------------------------------------
module display_scan_driver
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int IDX_W      = 2
) (
   input  logic                    clk50Mhz,
   input  logic                    rst,
   input  logic                    clk191hz,
   input  logic                    clk6hz,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic                    loaded,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [IDX_W-1:0]        digit_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   // ---------------------------------------------------------------- ticks
   logic w_scan_tick;
   logic w_blink_tick;

   tick_sync u_scan_sync (
      .clk     (clk50Mhz),
      .rst     (rst),
      .i_async (clk191hz),
      .o_tick  (w_scan_tick)
   );

   tick_sync u_blink_sync (
      .clk     (clk50Mhz),
      .rst     (rst),
      .i_async (clk6hz),
      .o_tick  (w_blink_tick)
   );

   // ------------------------------------------------------------ registers
   logic [IDX_W-1:0]            r_idx;
   logic [NUM_DIGITS-1:0][3:0]  r_disp;
   logic [NUM_DIGITS-1:0][3:0]  r_pend;
   logic                        r_pend_valid;
   logic                        r_phase;
   logic                        r_loaded;
   logic [NUM_DIGITS-1:0]       r_an_n;
   seg_t                        r_seg_n;
   logic                        r_dp_n;

   // ---------------------------------------------------------- next state
   logic [NUM_DIGITS-1:0][3:0]  w_value;
   logic [IDX_W-1:0]            w_idx_next;
   logic                        w_frame;
   logic                        w_commit;
   logic [NUM_DIGITS-1:0][3:0]  w_disp_next;
   logic                        w_phase_next;
   logic [NUM_DIGITS-1:0]       w_an_next;
   seg_t                        w_seg_next;
   logic                        w_dp_next;

   assign w_value = value;

   always_comb begin
      w_phase_next = r_phase ^ w_blink_tick;

      w_idx_next = r_idx;
      if (w_scan_tick) begin
         w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end

      // Frame boundary = scan tick that wraps the index back to digit 0.
      w_frame  = w_scan_tick && (r_idx == LAST_IDX);
      w_commit = w_frame && (r_pend_valid || load);

      // A load landing on the boundary bypasses pending and commits directly.
      w_disp_next = r_disp;
      if (w_commit) begin
         w_disp_next = load ? w_value : r_pend;
      end

      w_an_next = '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (w_idx_next == IDX_W'(i)) begin
            w_an_next[i] = 1'b0;
         end
      end

      // Output image is built from post-tick index, post-commit display and
      // post-toggle blink phase, so it is consistent with the new digit.
      w_seg_next = hex_decode(w_disp_next[w_idx_next]);
      w_dp_next  = ~dp[w_idx_next];
      if (w_phase_next && blink_mask[w_idx_next]) begin
         w_seg_next = SEG_BLANK;
         w_dp_next  = 1'b1;
      end
   end

   always_ff @(posedge clk50Mhz or posedge rst) begin
      if (rst) begin
         r_idx        <= LAST_IDX;
         r_disp       <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
         r_phase      <= 1'b0;
         r_loaded     <= 1'b0;
         r_an_n       <= '1;
         r_seg_n      <= SEG_BLANK;
         r_dp_n       <= 1'b1;
      end else begin
         r_idx    <= w_idx_next;
         r_disp   <= w_disp_next;
         r_phase  <= w_phase_next;
         r_loaded <= w_commit;

         if (w_commit) begin
            r_pend_valid <= 1'b0;
         end else if (load) begin
            r_pend       <= w_value;
            r_pend_valid <= 1'b1;
         end

         // Outputs only change on a scan tick: blink changes never cut a
         // digit's on-time short.
         if (w_scan_tick) begin
            r_an_n  <= w_an_next;
            r_seg_n <= w_seg_next;
            r_dp_n  <= w_dp_next;
         end
      end
   end

   assign loaded    = r_loaded;
   assign an_n      = r_an_n;
   assign seg_n     = r_seg_n;
   assign dp_n      = r_dp_n;
   assign digit_idx = r_idx;

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Consumes the divided scan clock (clk191hz, ~191 Hz) and blink clock (clk6hz, ~6 Hz) from the clock divider.
- Drives a NUM_DIGITS-digit, common-anode, multiplexed 7-segment display from the 50 MHz system clock domain.
- Samples the divided clocks as data and converts them to single-cycle ticks; it never uses them as clocks.
- Provides tear-free value loading (frame-boundary commit) and per-digit 6 Hz blinking.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
IDX_W, 2, width of digit index; equals clog2(NUM_DIGITS)

Ports:
clk50Mhz  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
clk191hz  input  1  divided scan clock from the divider, sampled as data
clk6hz  input  1  divided blink clock from the divider, sampled as data
value  input  4*NUM_DIGITS  hex nibbles; digit 0 = value[3:0]
load  input  1  one-cycle request to capture value
dp  input  NUM_DIGITS  decimal-point enable per digit, sampled live
blink_mask  input  NUM_DIGITS  1 = digit blinks
loaded  output  1  one-cycle pulse when a new value is committed to display
an_n  output  NUM_DIGITS  anode select, active-low, one-hot-low
seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  output  1  decimal point, active-low
digit_idx  output  IDX_W  currently driven digit

Behaviour:
- Reset (async assert, sync release): an_n all 1, seg_n 7'h7F, dp_n 1, loaded 0, digit_idx NUM_DIGITS-1, display and pending registers 0, pending_valid 0, blink_phase 0, all sync flops 0.
- Tick generation: each divided input passes a 2-FF synchronizer plus an edge register.
  - scan_tick = s2 & ~s3, high for exactly 1 cycle per rising edge of clk191hz, 2-3 cycles after the edge.
  - blink_tick is derived identically from clk6hz.
  - Falling edges generate nothing.
- Scan: on scan_tick, digit_idx increments and wraps NUM_DIGITS-1 -> 0. The wrap is the frame boundary.
  - Because of the reset value, the first scan_tick after reset selects digit 0 and is a frame boundary.
- Outputs are registered and update the cycle after scan_tick, from the new digit_idx.
  - an_n: bit digit_idx = 0, all others 1.
  - seg_n: hex decode of the selected nibble (0-F full hex font).
  - dp_n = ~dp[digit_idx].
- Blink: blink_phase toggles on each blink_tick.
  - While blink_phase=1 and blink_mask[digit_idx]=1: seg_n = 7'h7F and dp_n = 1; the anode stays driven.
  - A blink_phase change takes effect at the next scan_tick, not mid-digit.
- Load handshake:
  - load=1 copies value into pending and sets pending_valid.
  - Repeated loads before commit: last value wins.
  - On a frame-boundary scan_tick with pending_valid=1: display <= pending, pending_valid <= 0, loaded=1 for that cycle.
  - load coinciding with a frame-boundary tick: the new value commits directly, pending_valid ends 0, loaded=1.
  - Frame boundary with no pending data: display unchanged, loaded=0.
- Simultaneous scan_tick and blink_tick: both are handled in the same cycle; the output register uses the post-toggle blink_phase.
- Reset mid-frame: outputs blank immediately (async); any pending value is discarded.

Decomposition:
- Shared package display_pkg holds:
  - SEG_BLANK = 7'h7F
  - 16-entry active-low hex font constant SEG_FONT
  - seg_t typedef (7-bit)
- One sub-module, tick_sync: 2-FF synchronizer plus rising-edge detector with a single-cycle tick output. Instantiated twice (scan, blink).
- Hex decode is a package function or lookup; it is not a separate module.

Test Plan:
- Reset, then one clk191hz rising edge -> tick 2-3 cycles later; next cycle an_n=4'b1110, seg_n=SEG_FONT[0]=7'h40, digit_idx=0, loaded=0.
- load value=16'h1234, then 4 clk191hz edges -> loaded pulses once, at the frame-boundary tick only; then digits 0..3 show seg_n 7'h19, 7'h30, 7'h24, 7'h79 with an_n 1110, 1101, 1011, 0111.
- Two loads (16'hAAAA then 16'h5555) within one frame -> exactly one loaded pulse; display shows 5; A never appears.
- blink_mask=4'b0010, one clk6hz edge -> digit 1 gives seg_n=7'h7F, dp_n=1 with an_n=4'b1101 still asserted; digits 0, 2, 3 unaffected; the next clk6hz edge restores digit 1.
- load asserted in the same cycle as the frame-boundary scan_tick -> loaded=1 that cycle, new value shown on digit 0, pending_valid=0.
- rst asserted mid-frame with a pending load -> an_n=4'hF and seg_n=7'h7F immediately (no clock needed); after release and 4 scan edges, display shows 0000 and loaded stays 0.
